// File: rtl/bm_pkg.sv
// Shared definitions for the arena movement/bomb controller.
//   - CMD_*     : per-player command encoding (3 bits, 6-7 unused)
//   - coord_w   : bit width needed to index n items (minimum 1)
//   - cell_idx  : linear map index of cell (x, y) in a grid w columns wide
package bm_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_BOMB  = 3'd5;

  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cell_idx(input int unsigned x, input int unsigned y,
                                           input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/bm_move_check.sv
// Combinational per-player move decode and static legality.
//   cur_x/cur_y : player's current cell
//   cmd         : player's command
//   wall_map    : 1 = wall at cell y*GRID_W+x
//   bomb_map    : 1 = bomb at cell
//   is_move     : cmd is one of up/down/left/right
//   tgt_x/tgt_y : target cell (equals current cell when out of range)
//   static_ok   : target is in range and free of walls and bombs
module bm_move_check
  import bm_pkg::*;
#(
  parameter int unsigned GRID_W = 10,
  parameter int unsigned GRID_H = 10,
  localparam int unsigned XW = coord_w(GRID_W),
  localparam int unsigned YW = coord_w(GRID_H),
  localparam int unsigned NC = GRID_W * GRID_H,
  localparam int unsigned CW = coord_w(NC)
) (
  input  logic [XW-1:0] cur_x,
  input  logic [YW-1:0] cur_y,
  input  logic [2:0]    cmd,
  input  logic [NC-1:0] wall_map,
  input  logic [NC-1:0] bomb_map,
  output logic          is_move,
  output logic [XW-1:0] tgt_x,
  output logic [YW-1:0] tgt_y,
  output logic          static_ok
);

  logic          in_range;
  logic [CW-1:0] idx;

  // Bounds are tested before any arithmetic so an edge cell never wraps.
  always_comb begin
    is_move  = 1'b1;
    in_range = 1'b1;
    tgt_x    = cur_x;
    tgt_y    = cur_y;
    case (cmd)
      CMD_UP: begin
        if (cur_y == '0) in_range = 1'b0;
        else             tgt_y = cur_y - YW'(1);
      end
      CMD_DOWN: begin
        if (32'(cur_y) + 1 >= GRID_H) in_range = 1'b0;
        else                          tgt_y = cur_y + YW'(1);
      end
      CMD_LEFT: begin
        if (cur_x == '0) in_range = 1'b0;
        else             tgt_x = cur_x - XW'(1);
      end
      CMD_RIGHT: begin
        if (32'(cur_x) + 1 >= GRID_W) in_range = 1'b0;
        else                          tgt_x = cur_x + XW'(1);
      end
      default: is_move = 1'b0;
    endcase
    idx       = CW'(cell_idx(tgt_x, tgt_y, GRID_W));
    static_ok = in_range && !wall_map[idx] && !bomb_map[idx];
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Multi-player movement and bomb-placement controller.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd       : one 3-bit command per player per cycle
//   wall_map/bomb_map   : arena occupancy, 1 bit per cell
//   bomb_done           : pulse per player when one of its bombs exploded
//   pos_x/pos_y         : registered per-player position (flattened)
//   move_blocked        : pulse when an eligible move was rejected
//   bomb_valid/ready    : placement request channel to the bomb manager,
//   bomb_player/x/y       payload held stable until accepted
//   bomb_count          : live bombs per player (flattened)
module player_move_ctrl
  import bm_pkg::*;
#(
  parameter int unsigned GRID_W        = 10,
  parameter int unsigned GRID_H        = 10,
  parameter int unsigned NUM_P         = 2,
  parameter int unsigned MOVE_COOLDOWN = 4,
  parameter int unsigned MAX_BOMBS     = 1,
  // 32-bit field per player; field p is player p's reset coordinate
  parameter logic [32*NUM_P-1:0] START_X = {32'd8, 32'd1},
  parameter logic [32*NUM_P-1:0] START_Y = {32'd8, 32'd1},
  localparam int unsigned XW  = coord_w(GRID_W),
  localparam int unsigned YW  = coord_w(GRID_H),
  localparam int unsigned PW  = coord_w(NUM_P),
  localparam int unsigned BW  = coord_w(MAX_BOMBS + 1),
  localparam int unsigned NC  = GRID_W * GRID_H,
  localparam int unsigned CDW = coord_w(MOVE_COOLDOWN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_P-1:0]   cmd_valid,
  input  logic [3*NUM_P-1:0] cmd,
  input  logic [NC-1:0]      wall_map,
  input  logic [NC-1:0]      bomb_map,
  input  logic [NUM_P-1:0]   bomb_done,
  output logic [XW*NUM_P-1:0] pos_x,
  output logic [YW*NUM_P-1:0] pos_y,
  output logic [NUM_P-1:0]   move_blocked,
  output logic               bomb_valid,
  input  logic               bomb_ready,
  output logic [PW-1:0]      bomb_player,
  output logic [XW-1:0]      bomb_x,
  output logic [YW-1:0]      bomb_y,
  output logic [BW*NUM_P-1:0] bomb_count
);

  localparam int unsigned CW = coord_w(NC);

  // Position of p in the cyclic order that starts at base.
  function automatic int unsigned rr_dist(input int unsigned p, input int unsigned base);
    return (p + NUM_P - base) % NUM_P;
  endfunction

  logic [XW-1:0]  x_q [NUM_P], x_d [NUM_P], bx_q [NUM_P], bx_d [NUM_P], tgt_x [NUM_P];
  logic [YW-1:0]  y_q [NUM_P], y_d [NUM_P], by_q [NUM_P], by_d [NUM_P], tgt_y [NUM_P];
  logic [CDW-1:0] cd_q [NUM_P], cd_d [NUM_P];
  logic [BW-1:0]  cnt_q [NUM_P], cnt_d [NUM_P];
  logic [NUM_P-1:0] pend_q, pend_d, blk_q, blk_d;
  logic [NUM_P-1:0] eligible, is_move, static_ok, legal, accepted, contested, cand;
  logic [PW-1:0]  rr_q, rr_d, brr_q, brr_d, bp_q, bp_d;
  logic [XW-1:0]  bxo_q, bxo_d;
  logic [YW-1:0]  byo_q, byo_d;
  logic           bv_q, bv_d, hs, bomb_acc;
  int unsigned    mv_best, bb_best;

  assign hs = bv_q && bomb_ready;

  for (genvar p = 0; p < NUM_P; p++) begin : g_player
    bm_move_check #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
    ) u_check (
      .cur_x     (x_q[p]),
      .cur_y     (y_q[p]),
      .cmd       (cmd[3*p +: 3]),
      .wall_map  (wall_map),
      .bomb_map  (bomb_map),
      .is_move   (is_move[p]),
      .tgt_x     (tgt_x[p]),
      .tgt_y     (tgt_y[p]),
      .static_ok (static_ok[p])
    );
    assign eligible[p]            = cmd_valid[p] && (cd_q[p] == '0);
    assign pos_x[p*XW +: XW]      = x_q[p];
    assign pos_y[p*YW +: YW]      = y_q[p];
    assign bomb_count[p*BW +: BW] = cnt_q[p];
  end

  // Player-vs-player legality and conflict arbitration. A cell occupied by
  // another player is illegal even if that player is leaving it this cycle.
  always_comb begin
    legal     = '0;
    accepted  = '0;
    contested = '0;
    rr_d      = rr_q;
    mv_best   = NUM_P;
    for (int p = 0; p < NUM_P; p++) begin
      legal[p] = eligible[p] && is_move[p] && static_ok[p];
      for (int q = 0; q < NUM_P; q++) begin
        if (q != p && tgt_x[p] == x_q[q] && tgt_y[p] == y_q[q]) legal[p] = 1'b0;
      end
    end
    for (int p = 0; p < NUM_P; p++) begin
      accepted[p] = legal[p];
      for (int q = 0; q < NUM_P; q++) begin
        if (q != p && legal[p] && legal[q] && tgt_x[p] == tgt_x[q] && tgt_y[p] == tgt_y[q]) begin
          contested[p] = 1'b1;
          if (rr_dist(q, rr_q) < rr_dist(p, rr_q)) accepted[p] = 1'b0;
        end
      end
    end
    // The pointer only advances on a conflict, past the earliest winner.
    for (int p = 0; p < NUM_P; p++) begin
      if (accepted[p] && contested[p] && rr_dist(p, rr_q) < mv_best) begin
        mv_best = rr_dist(p, rr_q);
        rr_d    = PW'((p + 1) % NUM_P);
      end
    end
  end

  // Per-player next state and the bomb request channel.
  always_comb begin
    pend_d   = pend_q;
    blk_d    = '0;
    cand     = '0;
    bomb_acc = 1'b0;
    bv_d     = bv_q;
    bp_d     = bp_q;
    bxo_d    = bxo_q;
    byo_d    = byo_q;
    brr_d    = brr_q;
    bb_best  = NUM_P;
    for (int p = 0; p < NUM_P; p++) begin
      x_d[p]   = accepted[p] ? tgt_x[p] : x_q[p];
      y_d[p]   = accepted[p] ? tgt_y[p] : y_q[p];
      blk_d[p] = eligible[p] && is_move[p] && !accepted[p];
      if (accepted[p])         cd_d[p] = CDW'(MOVE_COOLDOWN);
      else if (cd_q[p] != '0)  cd_d[p] = cd_q[p] - CDW'(1);
      else                     cd_d[p] = cd_q[p];

      // Bomb command: capture the cell now; the request goes out later.
      bomb_acc = eligible[p] && (cmd[3*p +: 3] == CMD_BOMB) && !pend_q[p] &&
                 (32'(cnt_q[p]) < MAX_BOMBS) &&
                 !bomb_map[CW'(cell_idx(x_q[p], y_q[p], GRID_W))];
      bx_d[p] = bomb_acc ? x_q[p] : bx_q[p];
      by_d[p] = bomb_acc ? y_q[p] : by_q[p];
      if (hs && bp_q == PW'(p)) pend_d[p] = 1'b0;
      if (bomb_acc)             pend_d[p] = 1'b1;

      // Simultaneous handshake and explosion cancel out.
      cnt_d[p] = cnt_q[p];
      if (hs && bp_q == PW'(p)) begin
        if (!bomb_done[p]) cnt_d[p] = cnt_q[p] + BW'(1);
      end else if (bomb_done[p] && cnt_q[p] != '0) begin
        cnt_d[p] = cnt_q[p] - BW'(1);
      end

      cand[p] = pend_q[p] && !(hs && bp_q == PW'(p));
    end
    // Reload the output register when idle or when its request completes,
    // so requests can go out back to back.
    if (!bv_q || hs) begin
      bv_d = 1'b0;
      for (int p = 0; p < NUM_P; p++) begin
        if (cand[p] && rr_dist(p, brr_q) < bb_best) begin
          bb_best = rr_dist(p, brr_q);
          bv_d    = 1'b1;
          bp_d    = PW'(p);
          bxo_d   = bx_q[p];
          byo_d   = by_q[p];
          brr_d   = PW'((p + 1) % NUM_P);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_P; p++) begin
        x_q[p]   <= XW'(START_X[32*p +: 32]);
        y_q[p]   <= YW'(START_Y[32*p +: 32]);
        cd_q[p]  <= '0;
        cnt_q[p] <= '0;
        bx_q[p]  <= '0;
        by_q[p]  <= '0;
      end
      pend_q <= '0;
      blk_q  <= '0;
      rr_q   <= '0;
      brr_q  <= '0;
      bv_q   <= 1'b0;
      bp_q   <= '0;
      bxo_q  <= '0;
      byo_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_P; p++) begin
        x_q[p]   <= x_d[p];
        y_q[p]   <= y_d[p];
        cd_q[p]  <= cd_d[p];
        cnt_q[p] <= cnt_d[p];
        bx_q[p]  <= bx_d[p];
        by_q[p]  <= by_d[p];
      end
      pend_q <= pend_d;
      blk_q  <= blk_d;
      rr_q   <= rr_d;
      brr_q  <= brr_d;
      bv_q   <= bv_d;
      bp_q   <= bp_d;
      bxo_q  <= bxo_d;
      byo_q  <= byo_d;
    end
  end

  assign move_blocked = blk_q;
  assign bomb_valid   = bv_q;
  assign bomb_player  = bp_q;
  assign bomb_x       = bxo_q;
  assign bomb_y       = byo_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
`timescale 1ns/1ps
module tb_player_move_ctrl;

  localparam int GW = 10, GH = 10, NP = 2, COOL = 4, MAXB = 1;
  localparam int XW = 4, YW = 4, PW = 1, BW = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      cmd_valid, bomb_done, move_blocked;
  logic [3*NP-1:0]    cmd;
  logic [GW*GH-1:0]   wall_map, bomb_map;
  logic [XW*NP-1:0]   pos_x;
  logic [YW*NP-1:0]   pos_y;
  logic               bomb_valid, bomb_ready;
  logic [PW-1:0]      bomb_player;
  logic [XW-1:0]      bomb_x;
  logic [YW-1:0]      bomb_y;
  logic [BW*NP-1:0]   bomb_count;

  int checks = 0, errors = 0;

  player_move_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .NUM_P(NP), .MOVE_COOLDOWN(COOL), .MAX_BOMBS(MAXB),
    .START_X({32'd8, 32'd1}), .START_Y({32'd8, 32'd1})
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .wall_map(wall_map),
    .bomb_map(bomb_map), .bomb_done(bomb_done), .pos_x(pos_x), .pos_y(pos_y),
    .move_blocked(move_blocked), .bomb_valid(bomb_valid), .bomb_ready(bomb_ready),
    .bomb_player(bomb_player), .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_count(bomb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int mx[NP], my[NP], mcd[NP], mcnt[NP], mbx[NP], mby[NP];
  bit mpend[NP], mblk[NP];
  int mrr, mbrr, mbp, mbxo, mbyo;
  bit mbv;

  function automatic int start_c(input int p);
    return (p == 0) ? 1 : 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = start_c(i); my[i] = start_c(i); mcd[i] = 0; mcnt[i] = 0;
      mbx[i] = 0; mby[i] = 0; mpend[i] = 0; mblk[i] = 0;
    end
    mrr = 0; mbrr = 0; mbv = 0; mbp = 0; mbxo = 0; mbyo = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit elig[NP], ok[NP], win[NP], bacc[NP];
    int tx[NP], ty[NP], cx[NP], cy[NP];
    int c, p, q, ob, newrr, newb;
    bit hs, contested, found, first;
    if (rst) begin model_reset(); return; end
    hs = mbv && bomb_ready;
    ob = mbp;
    for (int i = 0; i < NP; i++) begin
      c = int'(cmd[3*i +: 3]);
      elig[i] = cmd_valid[i] && mcd[i] == 0;
      cx[i] = mx[i]; cy[i] = my[i];
      bacc[i] = elig[i] && c == 5 && !mpend[i] && mcnt[i] < MAXB && !bomb_map[my[i]*GW + mx[i]];
      ok[i] = 0; tx[i] = mx[i]; ty[i] = my[i]; mblk[i] = 0;
      if (elig[i] && c >= 1 && c <= 4) begin
        case (c)
          1: ty[i] = ty[i] - 1;
          2: ty[i] = ty[i] + 1;
          3: tx[i] = tx[i] - 1;
          default: tx[i] = tx[i] + 1;
        endcase
        ok[i] = tx[i] >= 0 && tx[i] < GW && ty[i] >= 0 && ty[i] < GH;
        if (ok[i]) ok[i] = !wall_map[ty[i]*GW + tx[i]] && !bomb_map[ty[i]*GW + tx[i]];
        for (int j = 0; j < NP; j++)
          if (j != i && tx[i] == mx[j] && ty[i] == my[j]) ok[i] = 0;
        mblk[i] = !ok[i];
      end
    end
    // Walk claimants in priority order from the pointer; later same-cell claimants lose.
    for (int i = 0; i < NP; i++) win[i] = ok[i];
    newrr = mrr; first = 1;
    for (int k = 0; k < NP; k++) begin
      p = (mrr + k) % NP; contested = 0;
      if (win[p])
        for (int j = k + 1; j < NP; j++) begin
          q = (mrr + j) % NP;
          if (ok[q] && tx[q] == tx[p] && ty[q] == ty[p]) begin
            win[q] = 0; mblk[q] = 1; contested = 1;
          end
        end
      if (contested && first) begin first = 0; newrr = (p + 1) % NP; end
    end
    mrr = newrr;
    for (int i = 0; i < NP; i++) begin
      if (win[i]) begin mx[i] = tx[i]; my[i] = ty[i]; mcd[i] = COOL; end
      else if (mcd[i] > 0) mcd[i] = mcd[i] - 1;
      if (hs && ob == i) begin
        if (!bomb_done[i]) mcnt[i] = mcnt[i] + 1;
      end else if (bomb_done[i] && mcnt[i] > 0) mcnt[i] = mcnt[i] - 1;
    end
    if (!mbv || hs) begin
      found = 0; newb = mbrr; mbv = 0;
      for (int k = 0; k < NP; k++) begin
        p = (mbrr + k) % NP;
        if (!found && mpend[p] && !(hs && ob == p)) begin
          found = 1; mbv = 1; mbp = p; mbxo = mbx[p]; mbyo = mby[p]; newb = (p + 1) % NP;
        end
      end
      mbrr = newb;
    end
    if (hs) mpend[ob] = 0;
    for (int i = 0; i < NP; i++)
      if (bacc[i]) begin mpend[i] = 1; mbx[i] = cx[i]; mby[i] = cy[i]; end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cmd_valid = '0; cmd = '0; bomb_done = '0;
  endtask

  // Walk player p to (x,y) one cell at a time (x first), then let its cooldown expire.
  task automatic move_to(input int p, input int x, input int y);
    logic [2:0] c;
    for (int i = 0; i < 300 && !(mx[p] == x && my[p] == y); i++) begin
      set_idle();
      if (mcd[p] == 0) begin
        c = (mx[p] < x) ? 3'd4 : (mx[p] > x) ? 3'd3 : (my[p] < y) ? 3'd2 : 3'd1;
        cmd_valid[p] = 1'b1; cmd[3*p +: 3] = c;
      end
      step();
    end
    set_idle();
    for (int i = 0; i < 10 && mcd[p] != 0; i++) step();
    checks++;
    if (pos_x[XW*p +: XW] !== XW'(x) || pos_y[YW*p +: YW] !== YW'(y)) begin
      errors++;
      $display("FAIL move_to p%0d: got (%0d,%0d) want (%0d,%0d)", p,
               pos_x[XW*p +: XW], pos_y[YW*p +: YW], x, y);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle(); wall_map = '0; bomb_map = '0; bomb_ready = 0; rst = 1;
    step(); step();
    rst = 0;
    checks++;
    if (pos_x !== {4'd8, 4'd1} || pos_y !== {4'd8, 4'd1}) begin
      errors++; $display("FAIL reset_pos: got x=%h y=%h want x=81 y=81", pos_x, pos_y);
    end
    checks++;
    if (bomb_valid !== 1'b0 || bomb_count !== '0 || move_blocked !== '0) begin
      errors++; $display("FAIL reset_ctrl: got valid=%b cnt=%b blk=%b want 0", bomb_valid,
                         bomb_count, move_blocked);
    end
  endtask

  task automatic test_bounds();
    move_to(0, 0, 5);
    cmd_valid = 2'b01; cmd = {3'd0, 3'd3};
    step();
    checks++;
    if (move_blocked[0] !== 1'b1 || pos_x[3:0] !== 4'd0 || pos_y[3:0] !== 4'd5) begin
      errors++; $display("FAIL bounds_left: got blk=%b pos=(%0d,%0d) want 1 (0,5)",
                         move_blocked[0], pos_x[3:0], pos_y[3:0]);
    end
    set_idle(); step();
    checks++;
    if (move_blocked[0] !== 1'b0) begin
      errors++; $display("FAIL bounds_pulse: got blk=%b want 0", move_blocked[0]);
    end
  endtask

  task automatic test_wall();
    move_to(0, 2, 4);
    wall_map[4*GW + 3] = 1'b1;
    cmd_valid = 2'b01; cmd = {3'd0, 3'd4};
    step();
    checks++;
    if (move_blocked[0] !== 1'b1 || pos_x[3:0] !== 4'd2 || pos_y[3:0] !== 4'd4) begin
      errors++; $display("FAIL wall_block: got blk=%b pos=(%0d,%0d) want 1 (2,4)",
                         move_blocked[0], pos_x[3:0], pos_y[3:0]);
    end
    // No cooldown after a rejection: an immediate move is accepted.
    cmd = {3'd0, 3'd1};
    step();
    checks++;
    if (move_blocked[0] !== 1'b0 || pos_y[3:0] !== 4'd3) begin
      errors++; $display("FAIL wall_no_cooldown: got blk=%b y=%0d want 0 3",
                         move_blocked[0], pos_y[3:0]);
    end
    set_idle(); wall_map = '0;
  endtask

  task automatic test_cooldown();
    move_to(0, 5, 5);
    cmd_valid = 2'b01; cmd = {3'd0, 3'd2};
    for (int k = 0; k <= 10; k++) begin
      step();
      checks++;
      if (pos_y[3:0] !== 4'(6 + k / 5)) begin
        errors++; $display("FAIL cooldown k=%0d: got y=%0d want %0d", k, pos_y[3:0], 6 + k / 5);
      end
    end
    set_idle();
    for (int i = 0; i < 10 && mcd[0] != 0; i++) step();
  endtask

  task automatic test_conflict();
    move_to(0, 4, 5);
    move_to(1, 6, 5);
    cmd_valid = 2'b11; cmd = {3'd3, 3'd4};
    step();
    checks++;
    if (pos_x[3:0] !== 4'd5 || pos_y[3:0] !== 4'd5 || move_blocked !== 2'b10 ||
        pos_x[7:4] !== 4'd6) begin
      errors++; $display("FAIL conflict_p0_wins: got p0=(%0d,%0d) p1x=%0d blk=%b want (5,5) 6 10",
                         pos_x[3:0], pos_y[3:0], pos_x[7:4], move_blocked);
    end
    set_idle();
    move_to(0, 4, 5);
    cmd_valid = 2'b11; cmd = {3'd3, 3'd4};
    step();
    checks++;
    if (pos_x[7:4] !== 4'd5 || pos_y[7:4] !== 4'd5 || move_blocked !== 2'b01 ||
        pos_x[3:0] !== 4'd4) begin
      errors++; $display("FAIL conflict_p1_wins: got p1=(%0d,%0d) p0x=%0d blk=%b want (5,5) 4 01",
                         pos_x[7:4], pos_y[7:4], pos_x[3:0], move_blocked);
    end
    set_idle();
  endtask

  task automatic test_bomb_budget();
    move_to(1, 8, 8);
    bomb_ready = 0;
    cmd_valid = 2'b10; cmd = {3'd5, 3'd0};
    step();
    set_idle();
    checks++;
    if (bomb_valid !== 1'b0) begin
      errors++; $display("FAIL bomb_latency: got valid=%b want 0", bomb_valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bomb_valid !== 1'b1 || bomb_player !== 1'b1 || bomb_x !== 4'd8 || bomb_y !== 4'd8) begin
        errors++; $display("FAIL bomb_hold k=%0d: got v=%b p=%0d (%0d,%0d) want 1 1 (8,8)",
                           k, bomb_valid, bomb_player, bomb_x, bomb_y);
      end
    end
    bomb_ready = 1;
    step();
    bomb_ready = 0;
    checks++;
    if (bomb_count[1] !== 1'b1 || bomb_valid !== 1'b0) begin
      errors++; $display("FAIL bomb_handshake: got cnt=%b valid=%b want 1 0",
                         bomb_count[1], bomb_valid);
    end
    cmd_valid = 2'b10; cmd = {3'd5, 3'd0};
    step();
    set_idle(); step(); step();
    checks++;
    if (bomb_valid !== 1'b0 || bomb_count[1] !== 1'b1) begin
      errors++; $display("FAIL bomb_budget_drop: got valid=%b cnt=%b want 0 1",
                         bomb_valid, bomb_count[1]);
    end
    bomb_done = 2'b10;
    step();
    set_idle();
    checks++;
    if (bomb_count[1] !== 1'b0) begin
      errors++; $display("FAIL bomb_done: got cnt=%b want 0", bomb_count[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0)
        for (int i = 0; i < GW*GH; i++) begin
          wall_map[i] = ($urandom_range(0, 9) == 0);
          bomb_map[i] = ($urandom_range(0, 19) == 0);
        end
      cmd_valid = 2'($urandom);
      for (int p = 0; p < NP; p++) begin
        cmd[3*p +: 3] = 3'($urandom_range(0, 7));
        bomb_done[p]  = ($urandom_range(0, 7) == 0);
      end
      bomb_ready = 1'($urandom_range(0, 1));
      step();
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (pos_x[XW*p +: XW] !== XW'(mx[p]) || pos_y[YW*p +: YW] !== YW'(my[p])) begin
          errors++; $display("FAIL rnd_pos n=%0d p%0d: got (%0d,%0d) want (%0d,%0d)", n, p,
                             pos_x[XW*p +: XW], pos_y[YW*p +: YW], mx[p], my[p]);
        end
        checks++;
        if (move_blocked[p] !== mblk[p]) begin
          errors++; $display("FAIL rnd_blocked n=%0d p%0d: got %b want %b", n, p,
                             move_blocked[p], mblk[p]);
        end
        checks++;
        if (bomb_count[BW*p +: BW] !== BW'(mcnt[p])) begin
          errors++; $display("FAIL rnd_count n=%0d p%0d: got %0d want %0d", n, p,
                             bomb_count[BW*p +: BW], mcnt[p]);
        end
      end
      checks++;
      if (bomb_valid !== mbv) begin
        errors++; $display("FAIL rnd_bomb_valid n=%0d: got %b want %b", n, bomb_valid, mbv);
      end else if (mbv) begin
        checks++;
        if (bomb_player !== PW'(mbp) || bomb_x !== XW'(mbxo) || bomb_y !== YW'(mbyo)) begin
          errors++; $display("FAIL rnd_bomb_payload n=%0d: got p=%0d (%0d,%0d) want p=%0d (%0d,%0d)",
                             n, bomb_player, bomb_x, bomb_y, mbp, mbxo, mbyo);
        end
      end
    end
    set_idle(); wall_map = '0; bomb_map = '0;
  endtask

  task automatic test_reset_mid_handshake();
    // Flush any leftover requests and live bombs from earlier traffic.
    bomb_ready = 1;
    for (int i = 0; i < 10; i++) step();
    bomb_done = 2'b11; step(); step();
    set_idle(); bomb_ready = 1;
    cmd_valid = 2'b01; cmd = {3'd0, 3'd5};
    step();
    set_idle(); step(); step();
    checks++;
    if (bomb_count[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_count: got %b want 1", bomb_count[0]);
    end
    bomb_ready = 0;
    cmd_valid = 2'b10; cmd = {3'd5, 3'd0};
    step();
    set_idle();
    for (int i = 0; i < 5 && !mbv; i++) step();
    checks++;
    if (bomb_valid !== 1'b1 || bomb_player !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got v=%b p=%0d want 1 1", bomb_valid, bomb_player);
    end
    rst = 1; bomb_ready = 1;
    step();
    rst = 0; bomb_ready = 0;
    checks++;
    if (pos_x !== {4'd8, 4'd1} || pos_y !== {4'd8, 4'd1}) begin
      errors++; $display("FAIL mid_reset_pos: got x=%h y=%h want 81 81", pos_x, pos_y);
    end
    checks++;
    if (bomb_valid !== 1'b0 || bomb_count !== '0 || bomb_player !== '0 || bomb_x !== '0 ||
        bomb_y !== '0) begin
      errors++; $display("FAIL mid_reset_bomb: got v=%b cnt=%b p=%0d (%0d,%0d) want all 0",
                         bomb_valid, bomb_count, bomb_player, bomb_x, bomb_y);
    end
    step();
    checks++;
    if (bomb_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_discard: got valid=%b want 0", bomb_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounds();
    test_wall();
    test_cooldown();
    test_conflict();
    test_bomb_budget();
    test_random();
    test_reset_mid_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Parametrised multi-player movement and bomb-placement controller for the arena game. It accepts one command per player per cycle and checks each move against the wall map, the bomb map, grid bounds and the other players. It arbitrates conflicting moves, rate-limits movement with per-player cooldown counters, and forwards bomb placements to the bomb manager over a valid/ready channel with a per-player bomb budget. It sits between the input decoders (buttons, UART player) and the arena/bomb state and display logic.

## Interface
Parameters:
- GRID_W, 10, arena columns (x range 0..GRID_W-1)
- GRID_H, 10, arena rows (y range 0..GRID_H-1)
- NUM_P, 2, number of players
- MOVE_COOLDOWN, 4, cycles a player is locked out after an accepted move; 0 means no lockout
- MAX_BOMBS, 1, live bombs allowed per player
- START_X / START_Y, {8,1} / {8,1}, flattened per-player reset coordinates; player p uses field p

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- cmd_valid  in  NUM_P  command present for player p
- cmd  in  3*NUM_P  per-player command: 0 none, 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1), 5 bomb, 6–7 ignored
- wall_map  in  GRID_W*GRID_H  1 = wall at cell y*GRID_W+x
- bomb_map  in  GRID_W*GRID_H  1 = bomb present at cell
- bomb_done  in  NUM_P  one-cycle pulse: a bomb owned by player p has exploded
- pos_x  out  XW*NUM_P  current x per player, XW=$clog2(GRID_W)
- pos_y  out  YW*NUM_P  current y per player, YW=$clog2(GRID_H)
- move_blocked  out  NUM_P  one-cycle pulse: an eligible move was rejected
- bomb_valid  out  1  bomb placement request
- bomb_ready  in  1  bomb manager accepts the request
- bomb_player  out  $clog2(NUM_P)  owner of the request
- bomb_x / bomb_y  out  XW / YW  cell of the request
- bomb_count  out  $clog2(MAX_BOMBS+1)*NUM_P  live bombs per player

## Operation
- Eligibility: a player is eligible when cmd_valid[p] is set and cooldown[p]==0. Commands from a player that is not eligible are dropped, never queued.
- Target computation: bounds are checked before any subtraction, so x==0 with "left" is out of range and never wraps.
- A move is rejected when any of the following holds:
  - the target is out of range;
  - wall_map or bomb_map is set at the target;
  - the target equals any other player's current position (this makes swaps and moves into a just-vacated cell fail);
  - the player loses a conflict.
- Conflict: two or more eligible players target the same legal cell. The first claimant at or after rr_ptr (cyclic order) wins; the others get move_blocked. rr_ptr then moves to winner+1 mod NUM_P. rr_ptr changes only when a conflict occurs.
- Accepted move: the position updates and cooldown[p] loads MOVE_COOLDOWN.
- Rejected move: no position change and no cooldown load.
- cooldown decrements by 1 each cycle while nonzero.
- Bomb command: sets pending[p] only when all of these hold: pending[p]==0, bomb_count[p]<MAX_BOMBS, and bomb_map is clear at the player's position. Otherwise the command is dropped silently.
- Bomb channel:
  - Bomb requests are arbitrated round-robin (separate pointer) among pending players.
  - The selected player's request is registered onto bomb_*.
  - The payload is the player's position captured when the bomb command is accepted.
  - Handshake completes on bomb_valid && bomb_ready: pending[p] clears and bomb_count[p] increments.
- bomb_done[p] decrements bomb_count[p], saturating at 0. An increment and a decrement in the same cycle leave the count unchanged.
- Reset values:
  - pos = START_X/START_Y;
  - cooldown, pending, bomb_count, rr pointers = 0;
  - bomb_valid = 0, bomb_player/x/y = 0;
  - move_blocked = 0.

## Timing
- Command sampled at edge t: pos_x/pos_y and move_blocked reflect it after edge t (1-cycle latency). Checks use pos and maps as they stand before edge t.
- After an accepted move at edge t, the player's next move can be accepted at edge t+MOVE_COOLDOWN+1.
- Bomb path:
  - Bomb command at edge t sets pending.
  - bomb_valid rises after edge t+1 at the earliest.
  - bomb_valid, bomb_player, bomb_x and bomb_y are held stable until the handshake.
  - After a handshake, the next request may be presented in the following cycle.
- A player may move while its bomb is pending; the bomb cell is fixed at capture.
- rst mid-handshake: bomb_valid drops at the reset edge and the request is discarded.

## Structure
- Package bm_pkg holds:
  - command encoding constants (CMD_NONE..CMD_BOMB);
  - a cell_idx(x,y,W) function;
  - a coordinate width helper.
- Sub-module bm_move_check (one instance per player): combinational target and static legality (bounds, wall, bomb). Player-vs-player checks and arbitration stay in the top module.

## Test plan
- Bounds: player 0 at (0,5), cmd left → move_blocked[0]=1, pos stays (0,5).
- Wall: wall at (3,4), player 0 at (2,4), cmd right → blocked, no cooldown load.
- Cooldown: MOVE_COOLDOWN=4, player 0 at (5,5), cmd down held every cycle → y=6 at edge t, 7 at t+5, 8 at t+10.
- Conflict: player 0 at (4,5) cmd right, player 1 at (6,5) cmd left, rr_ptr=0 → player 0 reaches (5,5) and player 1 is blocked. Repeating the same setup with player 0 starting at (4,5) again → player 1 wins.
- Bomb budget: MAX_BOMBS=1, player 1 at (8,8), bomb cmd, bomb_ready held low for 3 cycles:
  - bomb_valid is stable with x=8, y=8, player=1 throughout;
  - after the handshake, bomb_count[1]=1;
  - a second bomb cmd is dropped;
  - after bomb_done[1], bomb_count[1]=0.
- Reset with bomb_valid=1: rst for one cycle → positions return to START, bomb_valid=0, all counts 0.
